// File: rtl/slip_unescaper.sv
// SLIP-style unescaper: strips ESC sequences, marks frame ends, flags and counts malformed escapes.
// Output is a single registered beat with valid/ready handshake.
//
// state    | meaning
// S_NORMAL | next symbol is taken literally (END -> end marker, ESC -> enter S_ESC)
// S_ESC    | an ESC prefix was accepted; next symbol selects the escaped value
module slip_unescaper #(
    parameter int                      SYMBOL_WIDTH   = 8,
    parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_END     = 8'hC0,
    parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC     = 8'hDB,
    parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_END = 8'hDC,
    parameter logic [SYMBOL_WIDTH-1:0] SYMBOL_ESC_ESC = 8'hDD,
    parameter int                      ERR_CNT_WIDTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [SYMBOL_WIDTH-1:0]  i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [SYMBOL_WIDTH-1:0]  o_data,
    output logic                     o_end,
    output logic                     o_err,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    typedef enum logic {S_NORMAL = 1'b0, S_ESC = 1'b1} state_t;

    localparam int CNT_SUM_W = ERR_CNT_WIDTH + 1;

    state_t                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic [SYMBOL_WIDTH-1:0]  data_q, data_d;
    logic                     end_q, end_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic                    accept;
    logic                    sent;
    logic                    emit;
    logic [SYMBOL_WIDTH-1:0] emit_data;
    logic                    emit_end;
    logic                    emit_err;
    logic                    esc_err;
    logic [1:0]              err_inc;
    logic [ERR_CNT_WIDTH:0]  cnt_sum;

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;
    assign sent    = valid_q && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                S_NORMAL: if (i_data == SYMBOL_ESC) state_d = S_ESC;
                S_ESC:    if (i_data != SYMBOL_ESC) state_d = S_NORMAL;
                default:  state_d = S_NORMAL;
            endcase
        end
    end

    // End beats carry SYMBOL_END on the data lane, which is i_data itself.
    always_comb begin
        emit      = 1'b0;
        emit_data = i_data;
        emit_end  = 1'b0;
        emit_err  = 1'b0;
        esc_err   = 1'b0;
        if (accept) begin
            case (state_q)
                S_NORMAL: begin
                    if (i_data != SYMBOL_ESC) begin
                        emit     = 1'b1;
                        emit_end = (i_data == SYMBOL_END);
                    end
                end
                S_ESC: begin
                    if (i_data == SYMBOL_ESC) begin
                        esc_err = 1'b1;
                    end else begin
                        emit = 1'b1;
                        if (i_data == SYMBOL_ESC_END) begin
                            emit_data = SYMBOL_END;
                        end else if (i_data == SYMBOL_ESC_ESC) begin
                            emit_data = SYMBOL_ESC;
                        end else begin
                            emit_err = 1'b1;
                            emit_end = (i_data == SYMBOL_END);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        end_d   = end_q;
        err_d   = err_q;
        if (emit) begin
            valid_d = 1'b1;
            data_d  = emit_data;
            end_d   = emit_end;
            err_d   = emit_err;
        end else if (sent) begin
            valid_d = 1'b0;
        end

        err_inc = {1'b0, sent && err_q} + {1'b0, esc_err};
        cnt_sum = {1'b0, err_count_q} + CNT_SUM_W'(err_inc);
        if (cnt_sum[ERR_CNT_WIDTH]) begin
            err_count_d = '1;
        end else begin
            err_count_d = cnt_sum[ERR_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            end_q       <= end_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_end       = end_q;
    assign o_err       = err_q;
    assign o_err_count = err_count_q;

endmodule

// File: tb/tb_slip_unescaper.sv
// Directed + loopback bench for slip_unescaper; a frame-level model is compared every cycle,
// a second instance with a 2-bit error counter exercises saturation.
module tb_slip_unescaper;

    localparam logic [7:0] C_END  = 8'hC0;
    localparam logic [7:0] C_ESC  = 8'hDB;
    localparam logic [7:0] C_EEND = 8'hDC;
    localparam logic [7:0] C_EESC = 8'hDD;

    logic        i_clk   = 1'b0;
    logic        i_rst   = 1'b0;
    logic [7:0]  i_data  = 8'h00;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;

    logic        o_ready, o_end, o_err, o_valid;
    logic [7:0]  o_data;
    logic [15:0] o_err_count;
    logic        s_ready, s_end, s_err, s_valid;
    logic [7:0]  s_data;
    logic [1:0]  s_err_count;

    slip_unescaper u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_end(o_end), .o_err(o_err), .o_valid(o_valid), .i_ready(i_ready),
        .o_err_count(o_err_count)
    );

    slip_unescaper #(.ERR_CNT_WIDTH(2)) u_dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(s_ready),
        .o_data(s_data), .o_end(s_end), .o_err(s_err), .o_valid(s_valid), .i_ready(i_ready),
        .o_err_count(s_err_count)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    bit run    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: one-entry output buffer plus the escape decode rules.
    bit         m_valid, m_end, m_err, m_esc;
    logic [7:0] m_data;
    int         m_errs;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_valid = 0; m_data = 8'h00; m_end = 0; m_err = 0; m_esc = 0; m_errs = 0;
        end else begin
            bit acc, snt, emit, e_end, e_err;
            logic [7:0] d;
            acc   = i_valid && (!m_valid || i_ready);
            snt   = m_valid && i_ready;
            emit  = 0; e_end = 0; e_err = 0; d = i_data;
            if (snt && m_err) m_errs++;
            if (acc) begin
                if (!m_esc) begin
                    if (i_data == C_ESC) m_esc = 1;
                    else begin emit = 1; e_end = (i_data == C_END); end
                end else if (i_data == C_ESC) begin
                    m_errs++;
                end else begin
                    m_esc = 0; emit = 1;
                    if (i_data == C_EEND)      d = C_END;
                    else if (i_data == C_EESC) d = C_ESC;
                    else begin e_err = 1; e_end = (i_data == C_END); end
                end
            end
            if (emit) begin m_valid = 1; m_data = d; m_end = e_end; m_err = e_err; end
            else if (snt) m_valid = 0;
        end
    end

    always @(negedge i_clk) begin
        if (run) begin
            chk("o_valid", o_valid, m_valid);
            chk("o_ready", o_ready, !m_valid || i_ready);
            if (m_valid) begin
                chk("o_data", o_data, m_data);
                chk("o_end", o_end, m_end);
                chk("o_err", o_err, m_err);
            end
            chk("o_err_count", o_err_count, (m_errs > 65535) ? 65535 : m_errs);
            chk("sat_valid", s_valid, m_valid);
            chk("sat_err_count", s_err_count, (m_errs > 3) ? 3 : m_errs);
        end
    end

    // Beats transferred downstream, as {end, err, data}.
    logic [9:0] got[$];
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) got.push_back({o_end, o_err, o_data});
    end

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s, input bit rnd_ready);
        bit acc;
        int n;
        acc = 0; n = 0;
        i_data = s; i_valid = 1;
        while (!acc && n < 50) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            n++;
            if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) begin
            errors++; checks++;
            $display("FAIL send_timeout: symbol %0h not accepted in %0d cycles", s, n);
        end
        i_valid = 0;
    endtask

    task automatic chk_got(input string name, input int idx, input logic [9:0] exp);
        chk(name, (idx < got.size()) ? 32'(got[idx]) : 32'hFFFF, 32'(exp));
    endtask

    logic [7:0] stream[$];
    logic [9:0] exp_q[$];

    initial begin
        #1 i_rst = 1;
        #1 run = 1;
        idle(3);
        chk("reset_valid", o_valid, 0);
        chk("reset_data", o_data, 0);
        chk("reset_count", o_err_count, 0);
        i_rst = 0;
        idle(1);

        got.delete();
        send(8'h01, 0); send(C_END, 0); send(8'h02, 0);
        idle(3);
        chk("t1_count", got.size(), 3);
        chk_got("t1_beat0", 0, 10'h001);
        chk_got("t1_beat1", 1, 10'h2C0);
        chk_got("t1_beat2", 2, 10'h002);

        got.delete();
        send(C_ESC, 0); send(C_EEND, 0); send(C_ESC, 0); send(C_EESC, 0);
        idle(3);
        chk("t2_count", got.size(), 2);
        chk_got("t2_beat0", 0, 10'h0C0);
        chk_got("t2_beat1", 1, 10'h0DB);
        chk("t2_errcnt", o_err_count, 0);

        got.delete();
        send(C_ESC, 0); send(8'h55, 0); send(C_ESC, 0); send(C_END, 0);
        idle(3);
        chk_got("t3_beat0", 0, 10'h155);
        chk_got("t3_beat1", 1, 10'h3C0);
        chk("t3_errcnt", o_err_count, 2);

        i_ready = 0;
        send(8'h11, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("t4_hold_ready", o_ready, 0);
            chk("t4_hold_valid", o_valid, 1);
            chk("t4_hold_data", o_data, 8'h11);
            @(posedge i_clk);
            #1;
        end
        i_ready = 1;
        idle(2);

        got.delete(); stream.delete(); exp_q.delete();
        for (int i = 0; i < 100; i++) begin
            logic [7:0] sym;
            case ($urandom_range(0, 4))
                0: sym = C_END;
                1: sym = C_ESC;
                2: sym = C_EEND;
                default: sym = 8'($urandom_range(0, 255));
            endcase
            if (sym == C_END)      begin stream.push_back(C_ESC); stream.push_back(C_EEND); end
            else if (sym == C_ESC) begin stream.push_back(C_ESC); stream.push_back(C_EESC); end
            else stream.push_back(sym);
            exp_q.push_back({2'b00, sym});
            if ($urandom_range(0, 9) == 0) begin
                stream.push_back(C_END);
                exp_q.push_back({2'b10, C_END});
            end
        end
        foreach (stream[i]) begin
            send(stream[i], 1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        i_ready = 1;
        idle(4);
        chk("t4_loop_count", got.size(), exp_q.size());
        foreach (exp_q[i]) chk_got("t4_loop_beat", i, exp_q[i]);

        send(8'h33, 0);
        send(C_ESC, 0);
        i_rst = 1;
        @(negedge i_clk);
        chk("t5_rst_valid", o_valid, 0);
        idle(2);
        i_rst = 0;
        idle(1);
        got.delete();
        send(C_EEND, 0);
        idle(3);
        chk("t5_count", got.size(), 1);
        chk_got("t5_beat0", 0, 10'h0DC);
        chk("t5_errcnt", o_err_count, 0);

        got.delete();
        send(C_ESC, 0);
        repeat (6) send(C_ESC, 0);
        send(8'h55, 0);
        idle(3);
        chk_got("t6_beat0", 0, 10'h155);
        chk("t6_wide_count", o_err_count, 7);
        chk("t6_sat_count", s_err_count, 3);

        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
